// File: rtl/seq_pkg.sv
// Shared definitions for the term-sequencing controller: seeds, window depth
// and FSM state encoding.
package seq_pkg;

    localparam int WIN_DEPTH = 5;

    localparam int unsigned SEED0 = 0;
    localparam int unsigned SEED1 = 1;
    localparam int unsigned SEED2 = 1;
    localparam int unsigned SEED3 = 1;
    localparam int unsigned SEED4 = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_STEP = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic int unsigned seed_at(input int i);
        case (i)
            0:       return SEED0;
            1:       return SEED1;
            2:       return SEED2;
            3:       return SEED3;
            default: return SEED4;
        endcase
    endfunction

endpackage

// File: rtl/seq_window.sv
// Five-slot recurrence window a(k)..a(k+4) with per-slot overflow flags.
// One shift advances k by one; w4 takes a(k+5) = a(k+4) + a(k).
module seq_window
    import seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_seeds,
    input  logic             shift,
    output logic [WIDTH-1:0] w0,
    output logic             ovf0
);

    logic [WIDTH-1:0]     r_term [WIN_DEPTH];
    logic [WIN_DEPTH-1:0] r_ovf;
    logic [WIDTH:0]       w_sum;

    assign w_sum = {1'b0, r_term[WIN_DEPTH-1]} + {1'b0, r_term[0]};

    always_ff @(posedge clk) begin
        if (reset || load_seeds) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                r_term[i] <= WIDTH'(seed_at(i));
            end
            r_ovf <= '0;
        end else if (shift) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) begin
                r_term[i] <= r_term[i+1];
            end
            r_term[WIN_DEPTH-1] <= w_sum[WIDTH-1:0];
            // A wrap anywhere in the dependency chain sticks to the new term.
            r_ovf <= {w_sum[WIDTH] | r_ovf[WIN_DEPTH-1] | r_ovf[0], r_ovf[WIN_DEPTH-1:1]};
        end
    end

    assign w0   = r_term[0];
    assign ovf0 = r_ovf[0];

endmodule

// File: rtl/seq_term_ctrl.sv
// Request/response controller returning term a(idx) of the 5-term recurrence.
// Optional macro SEQ_RESUME_EN: keep the window between requests and step on from it.
module seq_term_ctrl
    import seq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_idx,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_term,
    output logic             rsp_ovf,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid, once raised, holds with its payload until that edge.

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_load_cnt;
    logic             w_resume;
    logic             w_load_seeds;
    logic             w_shift;
    logic             w_rsp_done;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_term;
    logic             r_rsp_ovf;
    logic [WIDTH-1:0] w_w0;
    logic             w_ovf0;

`ifdef SEQ_RESUME_EN
    logic [IDX_W-1:0] r_k;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_k <= '0;
        end else if (w_rsp_done) begin
            r_k <= r_idx;
        end
    end

    assign w_resume   = (r_idx >= r_k);
    assign w_load_cnt = w_resume ? (r_idx - r_k) : r_idx;
`else
    assign w_resume   = 1'b0;
    assign w_load_cnt = r_idx;
`endif

    assign w_rsp_done = (r_state == ST_RESP) && r_rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next = ST_LOAD;
            ST_LOAD: w_next = (w_load_cnt == '0) ? ST_RESP : ST_STEP;
            ST_STEP: if (r_cnt == IDX_W'(1)) w_next = ST_RESP;
            ST_RESP: if (w_rsp_done) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (r_state == ST_IDLE);
        busy         = (r_state != ST_IDLE);
        w_load_seeds = (r_state == ST_LOAD) && !w_resume;
        w_shift      = (r_state == ST_STEP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
            r_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && req_valid) r_idx <= req_idx;
            if (r_state == ST_LOAD) r_cnt <= w_load_cnt;
            else if (w_shift) r_cnt <= r_cnt - IDX_W'(1);
        end
    end

    // The result is registered, so valid rises one cycle after entering RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_term  <= '0;
            r_rsp_ovf   <= 1'b0;
        end else if (r_state == ST_RESP) begin
            r_rsp_valid <= !w_rsp_done;
            r_rsp_term  <= w_w0;
            r_rsp_ovf   <= w_ovf0;
        end else begin
            r_rsp_valid <= 1'b0;
        end
    end

    seq_window #(.WIDTH(WIDTH)) u_window (
        .clk        (clk),
        .reset      (reset),
        .load_seeds (w_load_seeds),
        .shift      (w_shift),
        .w0         (w_w0),
        .ovf0       (w_ovf0)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_term  = r_rsp_term;
    assign rsp_ovf   = r_rsp_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_term_ctrl.sv
// Table-driven bench for seq_term_ctrl: a 64-bit and an 8-bit instance driven in lock step.
module tb_seq_term_ctrl;
  import seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_idx = '0;
  logic        rsp_ready = 1'b0;

  logic        req_ready, rsp_valid, rsp_ovf, busy;
  logic [63:0] rsp_term;
  logic [1:0]  dbg_state;
  logic        req_ready8, rsp_valid8, rsp_ovf8, busy8;
  logic [7:0]  rsp_term8;
  logic [1:0]  dbg_state8;

  int n_checks = 0;
  int n_errors = 0;
  int model_k = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [7:0]  idx;
    logic [63:0] term64;
    logic [7:0]  term8;
    logic        ovf8;
  } vec_t;

  vec_t vecs[24];
  logic [63:0] terms[24];

  always #5 clk = ~clk;

  seq_term_ctrl #(.WIDTH(64), .IDX_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_term(rsp_term), .rsp_ovf(rsp_ovf), .busy(busy), .dbg_state(dbg_state)
  );

  seq_term_ctrl #(.WIDTH(8), .IDX_W(8)) dut8 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready8),
    .req_idx(req_idx), .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready),
    .rsp_term(rsp_term8), .rsp_ovf(rsp_ovf8), .busy(busy8), .dbg_state(dbg_state8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_latency(input int idx);
`ifdef SEQ_RESUME_EN
    if (idx >= model_k) return idx - model_k + 2;
`endif
    return idx + 2;
  endfunction

  // Issue one request, wait for the response, optionally stall, then take it.
  task automatic do_req(input logic [7:0] idx, input logic [63:0] exp64, input logic [7:0] exp8,
                        input logic exp_ovf8, input int stall, input bit poke);
    int cyc;
    int lat;
    logic [63:0] e;
    lat = exp_latency(int'(idx));
    exp_q.push_back(exp64);
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_idx   = idx;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(lat));
    check("rsp_valid8_sync", 64'(rsp_valid8), 64'd1);
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_term", rsp_term, exp64);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      if (poke) begin
        req_valid = 1'b1;
        req_idx   = 8'd3;
      end
      @(posedge clk); #1;
    end
    e = exp_q.pop_front();
    check("term64", rsp_term, e);
    check("ovf64", 64'(rsp_ovf), 64'd0);
    check("term8", 64'(rsp_term8), 64'(exp8));
    check("ovf8", 64'(rsp_ovf8), 64'(exp_ovf8));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_rsp_valid", 64'(rsp_valid), 64'd0);
    check("post_req_ready", 64'(req_ready), 64'd1);
    check("post_busy", 64'(busy), 64'd0);
    if (poke) begin
      @(posedge clk); #1;
      check("no_accept_in_resp", 64'(busy), 64'd0);
    end
    model_k = int'(idx);
  endtask

  initial begin
    bit seen;
    terms = '{64'd0, 64'd1, 64'd1, 64'd1, 64'd2, 64'd2, 64'd3, 64'd4, 64'd5, 64'd7,
              64'd9, 64'd12, 64'd16, 64'd21, 64'd28, 64'd37, 64'd49, 64'd65, 64'd86,
              64'd114, 64'd151, 64'd200, 64'd265, 64'd351};
    for (int i = 0; i < 24; i++) begin
      vecs[i].idx    = 8'(i);
      vecs[i].term64 = terms[i];
      vecs[i].term8  = terms[i][7:0];
      vecs[i].ovf8   = (i >= 22);
    end

    // Clock/reset block
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_term", rsp_term, 64'd0);
    check("rst_rsp_ovf", 64'(rsp_ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    model_k = 0;

    // Sweep idx 0..23 on both widths
    for (int i = 0; i < 24; i++) begin
      do_req(vecs[i].idx, vecs[i].term64, vecs[i].term8, vecs[i].ovf8, 0, 1'b0);
    end

    // Backpressure with a competing request held during RESP
    do_req(8'd10, 64'd9, 8'd9, 1'b0, 5, 1'b1);

    // Reset in the middle of a long STEP run
    @(negedge clk);
    req_valid = 1'b1;
    req_idx   = 8'd100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    seen = 1'b0;
    repeat (150) begin
      @(posedge clk); #1;
      seen |= rsp_valid | rsp_valid8;
    end
    check("abort_no_rsp", 64'(seen), 64'd0);
    model_k = 0;

    // Resume-style sequence (reseeds when the feature is off)
    do_req(8'd15, 64'd37, 8'd37, 1'b0, 0, 1'b0);
    do_req(8'd20, 64'd151, 8'd151, 1'b0, 0, 1'b0);
    do_req(8'd3, 64'd1, 8'd1, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
